// File: rtl/ingame_round_ctrl.sv
// Round controller for the tile-matching game: runs the countdown, counts matched pairs,
// and raises gameOver on a win or a timeout until the mode FSM drops ingameOn.
module ingame_round_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ROUND_SECONDS = 60,
  parameter int NUM_PAIRS     = 8
) (
  input  logic       CLOCK_50,
  input  logic       userquit,
  input  logic       ingameOn,
  input  logic       matchPulse,
  output logic       gameOver,
  output logic       win,
  output logic [6:0] secondsLeft,
  output logic [3:0] pairsFound,
  output logic [1:0] roundState
);

  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [6:0] SECS_INIT  = 7'(ROUND_SECONDS);
  localparam logic [3:0] PAIRS_WIN  = 4'(NUM_PAIRS);
  localparam logic [3:0] PAIRS_LAST = 4'(NUM_PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } roundState_t;

  roundState_t        state;
  logic [PRESC_W-1:0] prescaler;
  logic               tick;
  logic               winHit;
  logic               timeHit;

  // The last second expiring and the last pair arriving are both judged on the same edge.
  assign tick    = (prescaler == PRESC_LAST);
  assign winHit  = matchPulse && (pairsFound == PAIRS_LAST);
  assign timeHit = tick && (secondsLeft == 7'd1);

  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      state       <= IDLE;
      gameOver    <= 1'b0;
      win         <= 1'b0;
      secondsLeft <= '0;
      pairsFound  <= '0;
      prescaler   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ingameOn) begin
            state       <= RUN;
            secondsLeft <= SECS_INIT;
            pairsFound  <= '0;
            prescaler   <= '0;
          end
        end

        RUN: begin
          if (!ingameOn) begin
            // Abort wins over everything else in the same cycle.
            state       <= IDLE;
            gameOver    <= 1'b0;
            win         <= 1'b0;
            secondsLeft <= '0;
            pairsFound  <= '0;
            prescaler   <= '0;
          end else begin
            prescaler <= tick ? '0 : prescaler + PRESC_ONE;
            if (tick && (secondsLeft != 7'd0))
              secondsLeft <= secondsLeft - 7'd1;
            if (matchPulse && (pairsFound != PAIRS_WIN))
              pairsFound <= pairsFound + 4'd1;
            if (winHit || timeHit) begin
              state    <= DONE;
              gameOver <= 1'b1;
              win      <= winHit;
            end
          end
        end

        DONE: begin
          if (!ingameOn) begin
            state       <= IDLE;
            gameOver    <= 1'b0;
            win         <= 1'b0;
            secondsLeft <= '0;
            pairsFound  <= '0;
            prescaler   <= '0;
          end
        end

        default: begin
          state       <= IDLE;
          gameOver    <= 1'b0;
          win         <= 1'b0;
          secondsLeft <= '0;
          pairsFound  <= '0;
          prescaler   <= '0;
        end
      endcase
    end
  end

  assign roundState = state;

endmodule

// File: doc/ingame_round_ctrl.md
# ingame_round_ctrl

Round controller for the tile-matching game, and the producer of the `gameOver` signal that the game-mode FSM consumes. When the mode FSM raises `ingameOn`, this block starts a countdown round and counts matched tile pairs. It asserts `gameOver` when every pair has been found or the clock runs out, then holds it until the mode FSM drops `ingameOn`. Its counters also drive the HEX score and time displays.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: CLOCK_50 cycles per countdown second; must be ≥ 2.
- `ROUND_SECONDS`, default 60: round length in seconds; legal range 1..99.
- `NUM_PAIRS`, default 8: pairs needed to win; legal range 1..15.
- `CLOCK_50`  in  1  system clock; all state changes on the rising edge.
- `userquit`  in  1  reset, asynchronous and active-high.
- `ingameOn`  in  1  level from the mode FSM; high through both the in-game and end-game modes.
- `matchPulse`  in  1  one-cycle pulse from the tile logic for each newly matched pair.
- `gameOver`  out  1  registered; high while the round is finished.
- `win`  out  1  registered; valid while `gameOver` = 1. Value 1 means all pairs found, 0 means time expired.
- `secondsLeft`  out  7  registered remaining seconds.
- `pairsFound`  out  4  registered matched-pair count.
- `roundState`  out  2  current state, exposed for debug.

## Operation
- Three states: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10. The encoding 2'b11 is illegal and returns to IDLE on the next edge.
- Reset (`userquit` = 1, any cycle, asynchronous) forces the following values: state = IDLE, `gameOver` = 0, `win` = 0, `secondsLeft` = 0, `pairsFound` = 0, prescaler = 0.
- **IDLE**
  - Outputs hold their reset values.
  - If `ingameOn` = 1, go to RUN and load `secondsLeft` = ROUND_SECONDS, `pairsFound` = 0, prescaler = 0.
- **RUN**
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0. On the wrap cycle, `tick` = 1.
  - On `tick`, `secondsLeft` decrements by 1.
  - On `matchPulse`, `pairsFound` increments by 1, saturating at NUM_PAIRS.
  - Win condition: `matchPulse` = 1 and `pairsFound` = NUM_PAIRS-1. Go to DONE with `gameOver` = 1, `win` = 1. `pairsFound` becomes NUM_PAIRS.
  - Timeout condition: `tick` = 1 and `secondsLeft` = 1, with no win in the same cycle. Go to DONE with `gameOver` = 1, `win` = 0. `secondsLeft` becomes 0.
  - If the win and timeout conditions occur in the same cycle, the win takes priority. `win` = 1 and `secondsLeft` becomes 0.
  - Abort: `ingameOn` = 0 in RUN takes priority over win and timeout. Go to IDLE, clear all outputs, and never assert `gameOver`.
- **DONE**
  - `gameOver` stays 1 and `win`, `secondsLeft`, `pairsFound` are frozen.
  - `matchPulse` and the prescaler are ignored.
  - If `ingameOn` = 0, go to IDLE and clear all outputs.
- Width rules: the prescaler is $clog2(TICKS_PER_SEC) bits. `secondsLeft` never underflows below 0. `pairsFound` never exceeds NUM_PAIRS.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Round start:
  - `ingameOn` sampled high in IDLE at edge N gives RUN and loaded counters from edge N.
  - The first `tick` occurs TICKS_PER_SEC cycles after edge N.
- `gameOver` latency:
  - Rises at the same edge that samples the winning `matchPulse` or the final `tick`.
  - It is therefore visible one cycle after the pulse is presented.
- Game restart:
  - `gameOver` falls at the first edge that samples `ingameOn` = 0 in DONE.
  - The mode FSM's menu→in-game path therefore sees a clean `gameOver` = 0 before the next round.
- Back-to-back rounds: `ingameOn` must be low for at least one sampled edge between rounds. A level held continuously from DONE does not restart the round.
- Reset mid-round: outputs clear immediately (asynchronously). The first post-reset edge evaluates IDLE.

## Test plan
All scenarios use the bench parameters TICKS_PER_SEC = 4, ROUND_SECONDS = 3, NUM_PAIRS = 2.
- **Timeout:** raise `ingameOn`, send no matches → `secondsLeft` steps 3, 2, 1, 0 at 4-cycle intervals. `gameOver` = 1 and `win` = 0 exactly 12 cycles after RUN entry.
- **Win:** raise `ingameOn`, send `matchPulse` at cycles 2 and 5 → `pairsFound` = 1, then 2. `gameOver` = 1 and `win` = 1 at the edge sampling the second pulse, with `secondsLeft` = 2.
- **Simultaneous:** send the second `matchPulse` on the cycle of the final `tick` → `win` = 1, `secondsLeft` = 0, `gameOver` = 1.
- **Abort:** drop `ingameOn` in RUN at cycle 6 → IDLE at the next edge, all outputs 0, and `gameOver` never pulses.
- **Hold/release:**
  - In DONE, send 3 extra `matchPulse`s → `pairsFound` stays 2 and `gameOver` stays 1.
  - Drop `ingameOn` → `gameOver` = 0 next edge.
  - Re-raise `ingameOn` → a fresh round starts with `secondsLeft` = 3.
- **Async reset:** assert `userquit` between clock edges during RUN → all outputs 0 before the next edge, with `roundState` = 2'b00.
